uart_tx_sched: RTL and testbench

- Round-robin scheduler that shares one UART transmit path, including the existing baud_gen, between N_REQ requesters.
- Per granted request it:
  - latches the requester's byte and baud select;
  - drives baud_gen's baud_rate input;
  - sequences the serial frame on baud edges.
- Sits between client logic and the baud_gen instance; the tx line goes to the pad.

---
 rtl/uart_tx_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmit path and its baud_gen between N_REQ requesters.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bits.
module uart_tx_sched #(
    parameter int N_REQ     = 4,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ*DATA_BITS-1:0]   req_data,
    input  logic [N_REQ*2-1:0]           req_baud,
    output logic [N_REQ-1:0]             ack,
    output logic [1:0]                   baud_rate,
    input  logic                         baud_tick,
    output logic                         tx,
    output logic                         busy,
    output logic [N_REQ-1:0]             done
);

    localparam int RR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PAR,
`endif
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [RR_W-1:0]      rr_q, rr_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 skip_q, skip_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic [N_REQ-1:0]     ack_q, ack_d;
    logic [N_REQ-1:0]     done_q, done_d;
    logic [1:0]           baud_q, baud_d;
    logic                 tick_q, tick_d;
    logic                 tick_q2, tick2_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic                 bit_edge;
    logic                 grant_valid;
    logic [RR_W-1:0]      grant_idx;
    logic [DATA_BITS-1:0] grant_data;
    logic [1:0]           grant_baud;
    logic [N_REQ-1:0]     grant_onehot;
    int                   best_dist;

    assign bit_edge = tick_q & ~tick_q2;

    // Winner is the set request at the smallest rotational distance past the last winner.
    always_comb begin
        grant_valid  = 1'b0;
        grant_idx    = '0;
        grant_data   = '0;
        grant_baud   = '0;
        grant_onehot = '0;
        best_dist    = N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i] && (((i + 2 * N_REQ - 1 - int'(rr_q)) % N_REQ) < best_dist)) begin
                best_dist       = (i + 2 * N_REQ - 1 - int'(rr_q)) % N_REQ;
                grant_valid     = 1'b1;
                grant_idx       = RR_W'(i);
                grant_data      = req_data[i*DATA_BITS +: DATA_BITS];
                grant_baud      = req_baud[i*2 +: 2];
                grant_onehot    = '0;
                grant_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        skip_d     = skip_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        ack_d      = '0;
        done_d     = '0;
        baud_d     = baud_q;
        tick_d     = baud_tick;
        tick2_d    = tick_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    rr_d     = grant_idx;
                    shift_d  = grant_data;
                    baud_d   = grant_baud;
                    ack_d    = grant_onehot;
                    busy_d   = 1'b1;
                    skip_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^grant_data;
`endif
                    state_d  = ALIGN;
                end
            end
            // baud_gen restarts on a rate change, so the first edge after grant is unreliable.
            ALIGN: begin
                if (bit_edge) begin
                    if (!skip_q) begin
                        skip_d = 1'b1;
                    end else begin
                        tx_d    = 1'b0;
                        state_d = START;
                    end
                end
            end
            START: begin
                if (bit_edge) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_edge) begin
                    if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        tx_d       = parity_q;
                        state_d    = PAR;
`else
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = STOP;
`endif
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PAR: begin
                if (bit_edge) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_edge) begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        done_d  = N_REQ'(1) << rr_q;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_q       <= RR_W'(N_REQ - 1);
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            skip_q     <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ack_q      <= '0;
            done_q     <= '0;
            baud_q     <= 2'b11;
            tick_q     <= 1'b0;
            tick_q2    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            skip_q     <= skip_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            baud_q     <= baud_d;
            tick_q     <= tick_d;
            tick_q2    <= tick2_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign ack       = ack_q;
    assign done      = done_q;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign baud_rate = baud_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: a baud_gen stand-in, a UART-receiver style frame decoder
// and a round-robin arbitration model. Honours UART_TX_PARITY_EN for the expected frame length.
module tb_uart_tx_sched;

    localparam int N_REQ     = 4;
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
    localparam int P_BASE    = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS  = 1;
`else
    localparam int PAR_BITS  = 0;
`endif
    localparam int FRAME_BITS = 1 + DATA_BITS + PAR_BITS + STOP_BITS;

    logic                       clock;
    logic                       reset;
    logic [N_REQ-1:0]           req;
    logic [N_REQ*DATA_BITS-1:0] req_data;
    logic [N_REQ*2-1:0]         req_baud;
    logic [N_REQ-1:0]           ack;
    logic [1:0]                 baud_rate;
    logic                       baud_tick;
    logic                       tx;
    logic                       busy;
    logic [N_REQ-1:0]           done;

    int testsRun  = 0;
    int failCount = 0;
    int rrModel   = N_REQ - 1;

    typedef struct {
        logic [N_REQ-1:0] reqMask;
        logic [7:0]       dataByte;
        logic [1:0]       baud;
        logic [N_REQ-1:0] expAck;
        logic [N_REQ-1:0] ghost;
    } vec_t;

    vec_t vecs[5];

    uart_tx_sched #(
        .N_REQ    (N_REQ),
        .DATA_BITS(DATA_BITS),
        .STOP_BITS(STOP_BITS)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .req_baud (req_baud),
        .ack      (ack),
        .baud_rate(baud_rate),
        .baud_tick(baud_tick),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic int periodFor(input logic [1:0] b);
        return P_BASE << (3 - int'(b));
    endfunction

    // Expected line levels for one frame, bit 0 first; unused upper positions stay high.
    function automatic logic [15:0] buildFrame(input logic [7:0] d);
        logic [15:0] f;
        logic        par;
        f    = '1;
        f[0] = 1'b0;
        par  = 1'b0;
        for (int i = 0; i < DATA_BITS; i++) begin
            f[1 + i] = d[i];
            par      = par ^ d[i];
        end
        if (PAR_BITS == 1) f[1 + DATA_BITS] = par;
        return f;
    endfunction

    function automatic int modelWinner(input int rr, input logic [N_REQ-1:0] mask);
        for (int k = 1; k <= N_REQ; k++) begin
            if (mask[(rr + k) % N_REQ]) return (rr + k) % N_REQ;
        end
        return -1;
    endfunction

    // Stand-in for baud_gen: one-cycle tick every P clocks, restarting when the rate changes.
    initial begin
        int         tickCnt;
        logic [1:0] lastRate;
        baud_tick = 1'b0;
        tickCnt   = 0;
        lastRate  = 2'b11;
        forever begin
            @(negedge clock);
            if (!$isunknown(baud_rate) && baud_rate !== lastRate) begin
                lastRate = baud_rate;
                tickCnt  = 0;
            end
            tickCnt++;
            if (tickCnt >= periodFor(lastRate)) begin
                baud_tick = 1'b1;
                tickCnt   = 0;
            end else begin
                baud_tick = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        testsRun++;
        failCount++;
        $display("[TB] FAIL %s: got no event within bound, expected event", name);
    endtask

    task automatic applyStimulus(input logic [N_REQ-1:0] mask, input logic [N_REQ*8-1:0] d,
                                 input logic [N_REQ*2-1:0] b);
        @(negedge clock);
        req      = mask;
        req_data = d;
        req_baud = b;
    endtask

    task automatic applyReset(input int cycles);
        @(negedge clock);
        reset = 1'b1;
        req   = '0;
        repeat (cycles) begin
            @(posedge clock);
            #1;
            checkOutput("reset tx", 32'(tx), 32'd1);
            checkOutput("reset busy", 32'(busy), 32'd0);
            checkOutput("reset ack", 32'(ack), 32'd0);
            checkOutput("reset done", 32'(done), 32'd0);
            checkOutput("reset baud_rate", 32'(baud_rate), 32'd3);
        end
        @(negedge clock);
        reset   = 1'b0;
        rrModel = N_REQ - 1;
    endtask

    task automatic waitAck(input string tag, output bit ok, output int cycles);
        cycles = 0;
        ok     = 1'b0;
        while (!ok && cycles < 60) begin
            @(posedge clock);
            #1;
            cycles++;
            if (ack != '0) ok = 1'b1;
        end
        if (!ok) reportTimeout({tag, " ack"});
    endtask

    task automatic waitTxLow(input string tag, input int limit, output bit ok, output int cycles);
        cycles = 0;
        ok     = 1'b0;
        while (!ok && cycles < limit) begin
            @(posedge clock);
            #1;
            cycles++;
            if (tx == 1'b0) ok = 1'b1;
        end
        if (!ok) reportTimeout({tag, " start bit"});
    endtask

    // Follows one granted frame from ack to done, sampling tx mid-bit like a receiver would.
    task automatic runFrame(input string tag, input int expWin, input logic [7:0] expData,
                            input logic [1:0] expBaud, input bit dropReq,
                            input logic [N_REQ-1:0] ghost, input int expAckLat, output int gap);
        int          P;
        int          cnt;
        bit          ok;
        logic [15:0] got;
        P   = periodFor(expBaud);
        gap = 0;
        got = '1;
        waitAck(tag, ok, cnt);
        gap = cnt;
        if (!ok) return;
        if (expAckLat > 0) checkOutput({tag, " ack latency"}, 32'(cnt), 32'(expAckLat));
        checkOutput({tag, " ack"}, 32'(ack), 32'd1 << expWin);
        checkOutput({tag, " baud_rate"}, 32'(baud_rate), 32'(expBaud));
        checkOutput({tag, " busy at grant"}, 32'(busy), 32'd1);
        rrModel = expWin;
        if (dropReq) req = req & ~(N_REQ'(1) << expWin);
        @(posedge clock);
        #1;
        gap++;
        checkOutput({tag, " ack width"}, 32'(ack), 32'd0);
        waitTxLow(tag, 3 * P + 8, ok, cnt);
        gap += cnt;
        if (!ok) return;
        repeat (P / 2) @(posedge clock);
        #1;
        got[0] = tx;
        for (int k = 1; k < FRAME_BITS; k++) begin
            repeat (P) @(posedge clock);
            #1;
            got[k] = tx;
            if (k == 2) req = req | ghost;
            if (k == 5) req = req & ~ghost;
        end
        checkOutput({tag, " frame bits"}, 32'(got), 32'(buildFrame(expData)));
        cnt = 0;
        ok  = 1'b0;
        while (!ok && cnt < P) begin
            @(posedge clock);
            #1;
            cnt++;
            if (done != '0) ok = 1'b1;
        end
        if (!ok) begin
            reportTimeout({tag, " done"});
            return;
        end
        checkOutput({tag, " done"}, 32'(done), 32'd1 << expWin);
        checkOutput({tag, " done timing"}, 32'(cnt), 32'(P / 2));
        checkOutput({tag, " busy at done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int               gap;
        int               cnt;
        int               seen;
        int               expWin;
        bit               ok;
        logic [N_REQ-1:0] mask;
        logic [31:0]      rd;
        logic [7:0]       rb;

        reset    = 1'b1;
        req      = '0;
        req_data = '0;
        req_baud = '0;

        vecs[0] = '{reqMask: 4'b0100, dataByte: 8'hA5, baud: 2'b10, expAck: 4'b0100, ghost: 4'b0000};
        vecs[1] = '{reqMask: 4'b0001, dataByte: 8'h07, baud: 2'b11, expAck: 4'b0001, ghost: 4'b0100};
        vecs[2] = '{reqMask: 4'b1000, dataByte: 8'h00, baud: 2'b01, expAck: 4'b1000, ghost: 4'b0000};
        vecs[3] = '{reqMask: 4'b0110, dataByte: 8'h5A, baud: 2'b11, expAck: 4'b0010, ghost: 4'b0000};
        vecs[4] = '{reqMask: 4'b1001, dataByte: 8'hC3, baud: 2'b00, expAck: 4'b1000, ghost: 4'b0000};

        applyReset(3);

        // Start a frame, then hold reset for 5 cycles mid-stream.
        applyStimulus(4'b0001, {4{8'h3C}}, {4{2'b11}});
        waitAck("midstream", ok, cnt);
        req = '0;
        if (ok) waitTxLow("midstream", 40, ok, cnt);
        repeat (24) @(posedge clock);
        applyReset(5);

        // All requesting: grants rotate 0,1,2,3,0 with only the ALIGN wait between frames.
        applyStimulus(4'b1111, {8'h13, 8'h12, 8'h11, 8'h10}, {4{2'b11}});
        for (int f = 0; f < 5; f++) begin
            runFrame($sformatf("b2b%0d", f), f % 4, 8'h10 + 8'(f % 4), 2'b11, 1'b0, '0, 0, gap);
            if (f > 0)
                checkOutput($sformatf("b2b%0d gap", f),
                            32'((gap >= 2 * P_BASE - 1) && (gap <= 2 * P_BASE + 1)), 32'd1);
        end
        applyStimulus('0, '0, {4{2'b11}});

        for (int i = 0; i < 5; i++) begin
            expWin = 0;
            for (int b = 0; b < N_REQ; b++) if (vecs[i].expAck[b]) expWin = b;
            applyStimulus(vecs[i].reqMask, {4{vecs[i].dataByte}}, {4{vecs[i].baud}});
            runFrame($sformatf("row%0d", i), expWin, vecs[i].dataByte, vecs[i].baud, 1'b1,
                     vecs[i].ghost, 1, gap);
            applyStimulus('0, '0, {4{vecs[i].baud}});
            seen = 0;
            repeat (8) begin
                @(posedge clock);
                #1;
                if (ack != '0) seen++;
            end
            checkOutput($sformatf("row%0d idle ack", i), 32'(seen), 32'd0);
        end

        // Rate change: requester 1 at 19.2k, then requester 3 at 2400.
        applyReset(2);
        applyStimulus(4'b1010, {8'hC3, 8'h00, 8'h55, 8'h00}, {2'b00, 2'b00, 2'b11, 2'b00});
        runFrame("chg r1", 1, 8'h55, 2'b11, 1'b1, '0, 1, gap);
        checkOutput("chg baud held", 32'(baud_rate), 32'd3);
        runFrame("chg r3", 3, 8'hC3, 2'b00, 1'b1, '0, 0, gap);
        checkOutput("chg first edge ignored", 32'(gap >= 2 * periodFor(2'b00)), 32'd1);
        applyStimulus('0, '0, '0);

        // Reset in the middle of data bit 4 of an all-ones byte.
        applyStimulus(4'b0010, {4{8'hFF}}, {4{2'b11}});
        waitAck("dreset", ok, cnt);
        req = '0;
        if (ok) begin
            checkOutput("dreset ack", 32'(ack), 32'b0010);
            waitTxLow("dreset", 40, ok, cnt);
            repeat (P_BASE / 2 + 5 * P_BASE) @(posedge clock);
            #1;
            checkOutput("dreset busy before", 32'(busy), 32'd1);
        end
        applyReset(2);
        seen = 0;
        repeat (3 * P_BASE) begin
            @(posedge clock);
            #1;
            if (done != '0) seen++;
        end
        checkOutput("dreset no done", 32'(seen), 32'd0);
        applyStimulus(4'b0100, {4{8'h5A}}, {4{2'b11}});
        runFrame("dreset regrant", 2, 8'h5A, 2'b11, 1'b1, '0, 1, gap);
        applyStimulus('0, '0, {4{2'b11}});

        // Random masks, bytes and rates against the arbitration and frame model.
        for (int r = 0; r < 8; r++) begin
            mask   = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            rd     = $urandom;
            rb     = 8'($urandom);
            expWin = modelWinner(rrModel, mask);
            applyStimulus(mask, rd, rb);
            runFrame($sformatf("rand%0d", r), expWin, 8'(rd >> (8 * expWin)), 2'(rb >> (2 * expWin)),
                     1'b1, '0, 1, gap);
            applyStimulus('0, '0, rb);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
